// File: rtl/uart_tx_param.sv
// uart_tx_param: parameterised UART transmitter (start, DATA_BITS LSB first,
// optional parity, 1 or 2 stop bits), every bit held for CLK_FREQ/BAUD_RATE clocks.
//
// Optional feature macro: UART_TX_FIFO_EN
//   undefined : single holding register. s_ready is high only while idle, so
//               back-to-back frames are separated by idle-high cycles.
//   defined   : FIFO_DEPTH-entry FIFO. The next frame starts right after the
//               last stop-bit cycle with no gap.
//
// FSM states
//   state    | meaning
//   S_IDLE   | line idle high, waiting for a payload
//   S_START  | driving start bit (0)
//   S_DATA   | driving payload bit idx_q
//   S_PARITY | driving parity bit (skipped when PARITY = 0)
//   S_STOP   | driving stop bit stop_q (1)
module uart_tx_param #(
    parameter int CLK_FREQ   = 125_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic                 tx_busy,
    output logic                 uart_tx
);

    localparam int CLKS_PER_BIT = (BAUD_RATE > 0) ? (CLK_FREQ / BAUD_RATE) : 0;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W        = $clog2(DATA_BITS);
    localparam int CPB_M1       = CLKS_PER_BIT - 1;
    localparam int DB_M1        = DATA_BITS - 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CPB_M1[CNT_W-1:0];
    localparam logic [IDX_W-1:0] IDX_LAST  = DB_M1[IDX_W-1:0];
    localparam logic             STOP_LAST = (STOP_BITS == 2);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx_param: CLK_FREQ/BAUD_RATE must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
        $error("uart_tx_param: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 tx_q, tx_d;
    logic                 rdy_q;

    logic                 have_data;
    logic [DATA_BITS-1:0] head_data;
    logic                 load;
    logic                 push;
    logic                 bit_done;
    logic                 par_bit;

    assign bit_done = (cnt_q == '0);
    assign par_bit  = (PARITY == 1) ? ~(^data_q) : (^data_q);

`ifdef UART_TX_FIFO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = FIFO_DEPTH[PTR_W:0];

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wptr_q, rptr_q;
    logic [PTR_W:0]       count_q;
    logic                 full;

    assign full      = (count_q == FULL_CNT);
    assign have_data = (count_q != '0);
    assign head_data = mem_q[rptr_q];
    // A full FIFO still takes a push when the FSM pops in the same cycle.
    assign s_ready   = rdy_q && (!full || load);
    assign push      = s_valid && s_ready;

    // FIFO storage: payload memory, no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= s_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (load) begin
                rptr_q <= rptr_q + 1'b1;
            end
            case ({push, load})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
`else
    logic [DATA_BITS-1:0] hold_q;
    logic                 pend_q;

    assign have_data = pend_q;
    assign head_data = hold_q;
    assign s_ready   = rdy_q && (state_q == S_IDLE) && !pend_q;
    assign push      = s_valid && s_ready;

    // Holding register: one payload waits here until the FSM loads it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
            pend_q <= 1'b0;
        end else if (push) begin
            hold_q <= s_data;
            pend_q <= 1'b1;
        end else if (load) begin
            pend_q <= 1'b0;
        end
    end
`endif

    assign tx_busy = (state_q != S_IDLE) || have_data;
    assign uart_tx = tx_q;

    // Frame sequencing, bit timer and the registered line value for the next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        stop_d  = stop_q;
        data_d  = data_q;
        load    = 1'b0;
        tx_d    = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (have_data) begin
                    load    = 1'b1;
                    state_d = S_START;
                    cnt_d   = CNT_MAX;
                end
            end
            S_START: begin
                if (bit_done) begin
                    state_d = S_DATA;
                    cnt_d   = CNT_MAX;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    cnt_d = CNT_MAX;
                    if (idx_q == IDX_LAST) begin
                        stop_d  = 1'b0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_PARITY: begin
                if (bit_done) begin
                    state_d = S_STOP;
                    stop_d  = 1'b0;
                    cnt_d   = CNT_MAX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    if (stop_q == STOP_LAST) begin
                        // Chain straight into the next start bit when data is waiting.
                        if (have_data) begin
                            load    = 1'b1;
                            state_d = S_START;
                            cnt_d   = CNT_MAX;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        stop_d = 1'b1;
                        cnt_d  = CNT_MAX;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load) begin
            data_d = head_data;
        end

        unique case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = data_d[idx_d];
            S_PARITY: tx_d = par_bit;
            default:  tx_d = 1'b1;
        endcase
    end

    // State, timer, latched payload and registered serial output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            data_q  <= '0;
            tx_q    <= 1'b1;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
            rdy_q   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: three transmitter instances with different frame formats,
// driven by directed and random pushes and compared every cycle against a
// frame-schedule model (start time + payload per frame).
`timescale 1ns/1ps
module tb_uart_tx_param;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD0  = 100_000;
    localparam int BAUD1  = 250_000;
    localparam int BAUD2  = 333_333;
    localparam int FD     = 4;
    localparam int NI     = 3;
    localparam int MAXF   = 512;

    localparam int CPB [NI] = '{10, 4, 3};
    localparam int DB  [NI] = '{8, 7, 8};
    localparam int PM  [NI] = '{0, 2, 1};
    localparam int SB  [NI] = '{1, 2, 1};

`ifdef UART_TX_FIFO_EN
    localparam bit FIFO_MODE = 1'b1;
`else
    localparam bit FIFO_MODE = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NI-1:0]  vld;
    logic [7:0]     d0;
    logic [6:0]     d1;
    logic [7:0]     d2;
    logic [NI-1:0]  rdy;
    logic [NI-1:0]  busy;
    logic [NI-1:0]  tx;

    int fs   [NI][MAXF];
    int fdat [NI][MAXF];
    int fn   [NI];
    int last_end [NI];
    int k;
    int r_edge;
    int total;
    int bad;
    bit held;

    int lit0 [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    int lit1 [11] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    int lit2 [11] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 1};

    always #5 clk = ~clk;

    uart_tx_param #(
        .CLK_FREQ(CLK_HZ), .BAUD_RATE(BAUD0), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(FD)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .s_data(d0), .s_valid(vld[0]),
        .s_ready(rdy[0]), .tx_busy(busy[0]), .uart_tx(tx[0])
    );

    uart_tx_param #(
        .CLK_FREQ(CLK_HZ), .BAUD_RATE(BAUD1), .DATA_BITS(7),
        .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(FD)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .s_data(d1), .s_valid(vld[1]),
        .s_ready(rdy[1]), .tx_busy(busy[1]), .uart_tx(tx[1])
    );

    uart_tx_param #(
        .CLK_FREQ(CLK_HZ), .BAUD_RATE(BAUD2), .DATA_BITS(8),
        .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(FD)
    ) u_dut2 (
        .clk(clk), .rst_n(rst_n), .s_data(d2), .s_valid(vld[2]),
        .s_ready(rdy[2]), .tx_busy(busy[2]), .uart_tx(tx[2])
    );

    function automatic int flen(int i);
        return 1 + DB[i] + ((PM[i] != 0) ? 1 : 0) + SB[i];
    endfunction

    // Value of bit position j of a frame carrying 'data'.
    function automatic int frame_bit(int i, int data, int j);
        int ones;
        if (j == 0) return 0;
        if (j <= DB[i]) return (data >> (j - 1)) & 1;
        if (PM[i] != 0 && j == DB[i] + 1) begin
            ones = $countones(data);
            return (PM[i] == 2) ? (ones % 2) : (1 - (ones % 2));
        end
        return 1;
    endfunction

    function automatic int exp_line(int i);
        int lo;
        lo = (fn[i] > 8) ? fn[i] - 8 : 0;
        for (int q = lo; q < fn[i]; q++) begin
            if (k >= fs[i][q] && k < fs[i][q] + flen(i) * CPB[i])
                return frame_bit(i, fdat[i][q], (k - fs[i][q]) / CPB[i]);
        end
        return 1;
    endfunction

    function automatic int exp_busy(int i);
        return (k <= last_end[i]) ? 1 : 0;
    endfunction

    function automatic int exp_ready(int i);
        int queued;
        int popnext;
        int lo;
        if (k < r_edge) return 0;
        if (!FIFO_MODE) return (k > last_end[i]) ? 1 : 0;
        queued  = 0;
        popnext = 0;
        lo = (fn[i] > 8) ? fn[i] - 8 : 0;
        for (int q = lo; q < fn[i]; q++) begin
            if (fs[i][q] > k) queued++;
            if (fs[i][q] == k + 1) popnext = 1;
        end
        return (queued < FD || popnext != 0) ? 1 : 0;
    endfunction

    // Payload accepted on edge k+1: frames are sent in order, starting one
    // cycle after acceptance or right after the previous frame, whichever is later.
    task automatic sched(int i, int data);
        int s;
        s = k + 2;
        if (last_end[i] + 1 > s) s = last_end[i] + 1;
        if (fn[i] < MAXF) begin
            fs[i][fn[i]]   = s;
            fdat[i][fn[i]] = data;
            fn[i]++;
        end
        last_end[i] = s + flen(i) * CPB[i] - 1;
    endtask

    task automatic chk(input string nm, input int i, input logic act, input int expv);
        total++;
        if (act !== expv[0]) begin
            bad++;
            $display("FAIL %s inst=%0d cycle=%0d got=%b want=%0d", nm, i, k, act, expv);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NI; i++) begin
            fn[i]       = 0;
            last_end[i] = -100;
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        vld    = '0;
        d0     = '0;
        d1     = '0;
        d2     = '0;
        total  = 0;
        bad    = 0;
        k      = 0;
        r_edge = 1 << 30;
        clear_model();

        for (int c = 1; c <= 6000; c++) begin
            @(posedge clk);
            k = c;
            #1;

            for (int i = 0; i < NI; i++) begin
                chk("uart_tx", i, tx[i], exp_line(i));
                chk("tx_busy", i, busy[i], exp_busy(i));
                chk("s_ready", i, rdy[i], exp_ready(i));
            end

            if (k >= 7 && k < 107 && (k - 7) % 10 == 5)
                chk("lit_8n1_a5", 0, tx[0], lit0[(k - 7) / 10]);
            if (k == 106) chk("lit_busy_last", 0, busy[0], 1);
            if (k == 107) chk("lit_busy_fall", 0, busy[0], 0);
            if (k >= 7 && k < 51 && (k - 7) % 4 == 1)
                chk("lit_7e2_7f", 1, tx[1], lit1[(k - 7) / 4]);
            if (k == 50) chk("lit_2stop_busy", 1, busy[1], 1);
            if (k == 51) chk("lit_2stop_fall", 1, busy[1], 0);
            if (k >= 7 && k < 40 && (k - 7) % 3 == 1)
                chk("lit_8o1_55", 2, tx[2], lit2[(k - 7) / 3]);
            if (k == 95) chk("lit_even_par_55", 1, tx[1], 0);

            if (k == 3) begin
                rst_n  = 1'b1;
                r_edge = k + 1;
            end
            if (k == 3740) begin
                rst_n  = 1'b1;
                r_edge = k + 1;
            end

            vld = '0;
            if (k == 5) begin
                vld = '1;
                d0  = 8'hA5;
                d1  = 7'h7F;
                d2  = 8'h55;
            end else if (k == 60) begin
                vld[1] = 1'b1;
                d1     = 7'h55;
            end else if (k == 3700) begin
                vld[0] = 1'b1;
                d0     = 8'hC3;
            end else if (k == 3742) begin
                vld[0] = 1'b1;
                d0     = 8'h3C;
            end else if ((k >= 120 && k < 3000) || (k >= 3745 && k < 5800)) begin
                held = (k < 700) || (k >= 4000 && k < 4500);
                for (int i = 0; i < NI; i++)
                    vld[i] = held ? 1'b1 : ($urandom_range(0, 99) < 25);
                d0 = 8'($urandom);
                d1 = 7'($urandom);
                d2 = 8'($urandom);
            end

            if (vld[0] && exp_ready(0) != 0) sched(0, int'(d0));
            if (vld[1] && exp_ready(1) != 0) sched(1, int'(d1));
            if (vld[2] && exp_ready(2) != 0) sched(2, int'(d2));

            // Abort the 0xC3 frame 35 cycles after its start bit began.
            if (k == 3737) begin
                rst_n = 1'b0;
                #1;
                for (int i = 0; i < NI; i++) begin
                    chk("abort_tx_high", i, tx[i], 1);
                    chk("abort_busy_low", i, busy[i], 0);
                    chk("abort_ready_low", i, rdy[i], 0);
                end
                clear_model();
                r_edge = 1 << 30;
                vld    = '0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
